// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: one bit per clock, done pulse and overflow flag.
// Build option: define SHIFT_SIGNED_OF_EN to make LSL overflow a sticky signed (sign-change) flag.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             OF
);

  // state   | meaning
  // S_IDLE  | waiting for start; Y/OF hold the last result
  // S_SHIFT | one shift/rotate step per edge until count is consumed
  // S_DONE  | result valid, done pulse for this single cycle

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic             of_nxt;
  logic [AMT_W-1:0] count, count_nxt;
  logic [1:0]       op_q, op_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      Y     <= '0;
      OF    <= 1'b0;
      count <= '0;
      op_q  <= OP_LSL;
    end else begin
      state <= state_nxt;
      Y     <= y_nxt;
      OF    <= of_nxt;
      count <= count_nxt;
      op_q  <= op_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    y_nxt     = Y;
    of_nxt    = OF;
    count_nxt = count;
    op_nxt    = op_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          y_nxt     = A;
          of_nxt    = 1'b0;
          count_nxt = amt;
          op_nxt    = op;
          state_nxt = (amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        unique case (op_q)
          OP_LSL: begin
            y_nxt = {Y[WIDTH-2:0], 1'b0};
`ifdef SHIFT_SIGNED_OF_EN
            of_nxt = OF | (Y[WIDTH-1] ^ Y[WIDTH-2]);
`else
            of_nxt = OF | Y[WIDTH-1];
`endif
          end
          OP_LSR:  y_nxt = {1'b0, Y[WIDTH-1:1]};
          OP_ASR:  y_nxt = {Y[WIDTH-1], Y[WIDTH-1:1]};
          OP_ROL:  y_nxt = {Y[WIDTH-2:0], Y[WIDTH-1]};
          default: y_nxt = Y;
        endcase
        // Counter saturates at zero so the maximum amount can never wrap.
        if (count != '0) count_nxt = count - AMT_W'(1);
        if (count <= AMT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: edge-indexed reference model, directed cases, random traffic.
// Honours SHIFT_SIGNED_OF_EN the same way the design does.
module tb_shift_sequencer;
  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] A;
  logic [3:0]  amt;
  logic        busy;
  logic        done;
  logic [15:0] Y;
  logic        OF;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .amt(amt),
    .busy(busy), .done(done), .Y(Y), .OF(OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-operation result straight from the arithmetic meaning of each op.
  function automatic void calc(input logic [15:0] a, input logic [3:0] n, input logic [1:0] o,
                               output logic [15:0] y, output logic of);
    logic [31:0] w;
    logic signed [15:0] s;
    logic [15:0] su;
    of = 1'b0;
    case (o)
      2'b00: begin
        y = a << n;
`ifdef SHIFT_SIGNED_OF_EN
        // Sign changes at some step iff the top n+1 bits of a are not all equal.
        s  = $signed(a) >>> (4'd15 - n);
        su = s;
        of = (su != 16'h0000) && (su != 16'hFFFF);
`else
        w  = {16'h0000, a} << n;
        of = (w[31:16] != 16'h0000);
`endif
      end
      2'b01: y = a >> n;
      2'b10: begin
        s = $signed(a) >>> n;
        y = s;
      end
      default: begin
        w = {a, a} << n;
        y = w[31:16];
      end
    endcase
  endfunction

  // Model: operation accepted at edge m_acc, done visible after edge m_end = m_acc + amt.
  int          edge_n = 0;
  int          m_acc  = -10;
  int          m_end  = -10;
  logic [15:0] m_y    = 16'h0000;
  logic        m_of   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = -10;
      m_end = -10;
      m_y   = 16'h0000;
      m_of  = 1'b0;
    end else begin
      edge_n++;
      if (edge_n >= m_end + 2 && start) begin
        m_acc = edge_n;
        m_end = edge_n + int'(amt);
        calc(A, amt, op, m_y, m_of);
      end
    end
  end

  always @(negedge clk) begin
    logic eb, ed;
    eb = (edge_n >= m_acc) && (edge_n <= m_end);
    ed = (edge_n == m_end);
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(ed));
    if (edge_n >= m_end) begin
      chk("Y", 32'(Y), 32'(m_y));
      chk("OF", 32'(OF), 32'(m_of));
    end
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Called at negedge+1 with the DUT idle; returns at negedge+1 with the DUT idle again.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [3:0] n,
                        input logic [1:0] o, input logic [15:0] ey, input logic eof,
                        input int elat, input bit poke);
    int lat;
    int nb;
    start = 1'b1; A = a; amt = n; op = o;
    @(posedge clk);
    lat = 1;
    nb  = 0;
    @(negedge clk);
    #1;
    start = 1'b0;
    A = 16'($urandom); amt = 4'($urandom); op = 2'($urandom);
    while (lat < 40) begin
      if (busy) nb++;
      if (done) break;
      start = poke && (lat == 5);
      if (start) A = 16'hFFFF;
      step();
      lat++;
    end
    start = 1'b0;
    if (lat >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d edges", nm, lat);
    end else begin
      chk({nm, "_lat"}, 32'(lat), 32'(elat));
      chk({nm, "_Y"}, 32'(Y), 32'(ey));
      chk({nm, "_OF"}, 32'(OF), 32'(eof));
      chk({nm, "_busycyc"}, 32'(nb), 32'(elat));
    end
    step();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; A = 16'h0; amt = 4'h0; op = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_Y", 32'(Y), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    step();

    run_op("lsl_carry", 16'h8001, 4'd1, 2'b00, 16'h0002, 1'b1, 2, 1'b0);
`ifdef SHIFT_SIGNED_OF_EN
    run_op("lsl_4000", 16'h4000, 4'd1, 2'b00, 16'h8000, 1'b1, 2, 1'b0);
`else
    run_op("lsl_4000", 16'h4000, 4'd1, 2'b00, 16'h8000, 1'b0, 2, 1'b0);
`endif
    run_op("asr", 16'hF000, 4'd4, 2'b10, 16'hFF00, 1'b0, 5, 1'b0);
    run_op("lsr", 16'hF000, 4'd4, 2'b01, 16'h0F00, 1'b0, 5, 1'b0);
    run_op("amt0", 16'h1234, 4'd0, 2'b01, 16'h1234, 1'b0, 1, 1'b0);
    run_op("rol15", 16'h0001, 4'd15, 2'b11, 16'h8000, 1'b0, 16, 1'b1);

    // Abort mid-shift: outputs clear at once and no done follows.
    start = 1'b1; A = 16'h00FF; amt = 4'd8; op = 2'b00;
    @(posedge clk);
    @(negedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_Y", 32'(Y), 32'h0);
    chk("abort_OF", 32'(OF), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    cnt = 0;
    repeat (3) begin
      step();
      if (done) cnt++;
    end
    chk("abort_nodone", 32'(cnt), 32'h0);
    rst = 1'b0;
    run_op("rst_start", 16'h1234, 4'd2, 2'b01, 16'h048D, 1'b0, 3, 1'b0);

    // Start held high: one accept every amt+2 cycles, one done each.
    start = 1'b1; A = 16'h00F0; amt = 4'd2; op = 2'b00;
    cnt = 0;
    repeat (16) begin
      step();
      if (done) cnt++;
    end
    chk("b2b_dones", 32'(cnt), 32'd4);
    start = 1'b0;
    repeat (5) step();

    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) != 0);
      A     = 16'($urandom);
      op    = 2'($urandom);
      case ($urandom_range(0, 5))
        0:       amt = 4'd0;
        1:       amt = 4'd15;
        default: amt = 4'($urandom);
      endcase
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
